// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 8:1 mux: steps {sel1,sel2,sel3} over all channels, samples z, packs a byte.
// Optional parity output when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          MSB_FIRST     = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       z_i,
    output logic       sel1_o,
    output logic       sel2_o,
    output logic       sel3_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] data_out_o
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] FIRST_CH    = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_CH     = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam state_t     ENTRY_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t     state_q;
    logic [2:0] ch_q;
    logic [2:0] ch_d;
    logic [3:0] cnt_q;
    logic [2:0] sel_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] shadow_q;
    logic [7:0] shadow_d;
    logic [7:0] data_q;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_q;
`endif

    assign ch_d = MSB_FIRST ? (ch_q - 3'd1) : (ch_q + 3'd1);

    // Shadow including the sample taken at the current edge, so DONE can publish all 8 bits at once.
    always_comb begin
        shadow_d       = shadow_q;
        shadow_d[ch_q] = z_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ch_q     <= 3'd0;
            cnt_q    <= 4'd0;
            sel_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sel_q  <= 3'd0;
                    busy_q <= 1'b0;
                    if (start_i && !abort_i) begin
                        ch_q    <= FIRST_CH;
                        sel_q   <= FIRST_CH;
                        cnt_q   <= SETTLE_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ENTRY_STATE;
                    end
                end
                SETTLE: begin
                    if (abort_i) begin
                        state_q  <= IDLE;
                        sel_q    <= 3'd0;
                        busy_q   <= 1'b0;
                        shadow_q <= 8'h00;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort_i) begin
                        state_q  <= IDLE;
                        sel_q    <= 3'd0;
                        busy_q   <= 1'b0;
                        shadow_q <= 8'h00;
                    end else if (ch_q == LAST_CH) begin
                        shadow_q <= shadow_d;
                        data_q   <= shadow_d;
`ifdef MUX_SCAN_PARITY_EN
                        parity_q <= ^shadow_d;
`endif
                        done_q   <= 1'b1;
                        sel_q    <= 3'd0;
                        state_q  <= DONE;
                    end else begin
                        shadow_q <= shadow_d;
                        ch_q     <= ch_d;
                        sel_q    <= ch_d;
                        cnt_q    <= SETTLE_INIT;
                        state_q  <= ENTRY_STATE;
                    end
                end
                DONE: begin
                    // abort and start are both ignored here; the result is already published.
                    state_q <= IDLE;
                    sel_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {sel1_o, sel2_o, sel3_o} = sel_q;
    assign busy_o                   = busy_q;
    assign done_o                   = done_q;
    assign data_out_o               = data_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity_o                 = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (S=1 LSB-first, S=0 MSB-first) share control inputs.
module tb_mux_scan_sequencer;

    localparam int SA = 1;
    localparam bit MA = 1'b0;
    localparam int SB = 0;
    localparam bit MB = 1'b1;
    localparam int NCYC = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [7:0] pat_a, pat_b;
    logic       za, zb;
    logic       a_sel1, a_sel2, a_sel3, a_busy, a_done;
    logic       b_sel1, b_sel2, b_sel3, b_busy, b_done;
    logic [7:0] a_data, b_data;
    logic       a_par, b_par;

    assign za = pat_a[{a_sel1, a_sel2, a_sel3}];
    assign zb = pat_b[{b_sel1, b_sel2, b_sel3}];

    mux_scan_sequencer #(.SETTLE_CYCLES(SA), .MSB_FIRST(MA)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .z_i(za),
        .sel1_o(a_sel1), .sel2_o(a_sel2), .sel3_o(a_sel3),
        .busy_o(a_busy), .done_o(a_done), .data_out_o(a_data)
`ifdef MUX_SCAN_PARITY_EN
        , .parity_o(a_par)
`endif
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(SB), .MSB_FIRST(MB)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .z_i(zb),
        .sel1_o(b_sel1), .sel2_o(b_sel2), .sel3_o(b_sel3),
        .busy_o(b_busy), .done_o(b_done), .data_out_o(b_data)
`ifdef MUX_SCAN_PARITY_EN
        , .parity_o(b_par)
`endif
    );

`ifndef MUX_SCAN_PARITY_EN
    assign a_par = 1'b0;
    assign b_par = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] prev_a = 8'h00;
    logic [7:0] prev_b = 8'h00;

    typedef struct {
        logic [7:0] pa;
        logic [7:0] pb;
        int         abort_c;
        int         rst_c;
        int         bs1;
        int         bs2;
        logic [7:0] xa;
        logic [7:0] xb;
        int         dna;
        int         dnb;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected outputs in cycle c of a scan requested in cycle 0, from the timing rules alone.
    function automatic void model(input int s, input bit msb, input int c, input int abort_c,
                                  input int rst_c, input logic [7:0] pat, input logic [7:0] prev,
                                  output logic busy, output logic done, output logic [2:0] sel,
                                  output logic [7:0] data);
        int len;
        int idx;
        len  = 8 * (s + 1);
        busy = 1'b0;
        done = 1'b0;
        sel  = 3'd0;
        data = prev;
        if (rst_c >= 0 && c > rst_c) begin
            data = 8'h00;
            return;
        end
        if (abort_c == 0) return;
        if (abort_c >= 1 && abort_c <= len && c > abort_c) return;
        if (c >= 1 && c <= len) begin
            busy = 1'b1;
            idx  = (c - 1) / (s + 1);
            sel  = msb ? 3'(7 - idx) : 3'(idx);
        end else if (c == len + 1) begin
            busy = 1'b1;
            done = 1'b1;
            data = pat;
        end else if (c > len + 1) begin
            data = pat;
        end
    endfunction

    task automatic check_one(input string tag, input int c, input logic eb, input logic ed,
                             input logic [2:0] es, input logic [7:0] edat, input logic busy,
                             input logic done, input logic [2:0] sel, input logic [7:0] data,
                             input logic par);
        chk($sformatf("%s_busy c%0d", tag, c), int'(busy), int'(eb));
        chk($sformatf("%s_done c%0d", tag, c), int'(done), int'(ed));
        chk($sformatf("%s_sel c%0d", tag, c), int'(sel), int'(es));
        chk($sformatf("%s_data c%0d", tag, c), int'(data), int'(edat));
`ifdef MUX_SCAN_PARITY_EN
        chk($sformatf("%s_parity c%0d", tag, c), int'(par), int'(^edat));
`else
        if (par !== 1'b0) $display("note: %s parity tie-off is %b", tag, par);
`endif
    endtask

    task automatic run_scan(input logic [7:0] pa, input logic [7:0] pb, input int abort_c,
                            input int rst_c, input int bs1, input int bs2,
                            output int dca, output int dcb);
        logic       eb, ed;
        logic [2:0] es;
        logic [7:0] ea_last, eb_last, edat;
        dca     = 0;
        dcb     = 0;
        ea_last = prev_a;
        eb_last = prev_b;
        pat_a   = pa;
        pat_b   = pb;
        for (int c = 0; c < NCYC; c++) begin
            start = (c == 0) || (c == bs1) || (c == bs2);
            abort = (c == abort_c);
            rst   = (c == rst_c);
            #3;
            model(SA, MA, c, abort_c, rst_c, pa, prev_a, eb, ed, es, edat);
            check_one("a", c, eb, ed, es, edat, a_busy, a_done, {a_sel1, a_sel2, a_sel3}, a_data, a_par);
            ea_last = edat;
            model(SB, MB, c, abort_c, rst_c, pb, prev_b, eb, ed, es, edat);
            check_one("b", c, eb, ed, es, edat, b_busy, b_done, {b_sel1, b_sel2, b_sel3}, b_data, b_par);
            eb_last = edat;
            if (a_done) dca++;
            if (b_done) dcb++;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        abort  = 1'b0;
        rst    = 1'b0;
        prev_a = ea_last;
        prev_b = eb_last;
    endtask

    vec_t tbl[8];

    initial begin
        int dca, dcb;
        int pa_per, pb_per;
        int ab, rs;

        tbl[0] = '{8'hA5, 8'h3C, -1, -1, -1, -1, 8'hA5, 8'h3C, 1, 1};
        tbl[1] = '{8'h5A, 8'hC3, -1, -1,  3,  8, 8'h5A, 8'hC3, 1, 1};
        tbl[2] = '{8'hFF, 8'h00,  6, -1,  3, -1, 8'h5A, 8'hC3, 0, 0};
        tbl[3] = '{8'h81, 8'h7E, 12, -1, -1, -1, 8'h5A, 8'h7E, 0, 1};
        tbl[4] = '{8'h0F, 8'hF0, -1, 10, -1, -1, 8'h00, 8'h00, 0, 1};
        tbl[5] = '{8'h07, 8'h03, 17, -1, -1, -1, 8'h07, 8'h03, 1, 1};
        tbl[6] = '{8'h99, 8'h66,  0, -1, -1, -1, 8'h07, 8'h03, 0, 0};
        tbl[7] = '{8'h03, 8'h07, -1,  0, -1, -1, 8'h00, 8'h00, 0, 0};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pat_a = 8'h00;
        pat_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            #3;
            check_one("rst_a", c, 1'b0, 1'b0, 3'd0, 8'h00, a_busy, a_done, {a_sel1, a_sel2, a_sel3}, a_data, a_par);
            check_one("rst_b", c, 1'b0, 1'b0, 3'd0, 8'h00, b_busy, b_done, {b_sel1, b_sel2, b_sel3}, b_data, b_par);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8; i++) begin
            run_scan(tbl[i].pa, tbl[i].pb, tbl[i].abort_c, tbl[i].rst_c, tbl[i].bs1, tbl[i].bs2, dca, dcb);
            chk($sformatf("vec%0d_final_a", i), int'(a_data), int'(tbl[i].xa));
            chk($sformatf("vec%0d_final_b", i), int'(b_data), int'(tbl[i].xb));
            chk($sformatf("vec%0d_dones_a", i), dca, tbl[i].dna);
            chk($sformatf("vec%0d_dones_b", i), dcb, tbl[i].dnb);
        end

        // start held high: a fresh scan begins every time IDLE is reached
        pa_per = 8 * (SA + 1) + 2;
        pb_per = 8 * (SB + 1) + 2;
        pat_a  = 8'hC6;
        pat_b  = 8'h29;
        start  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #3;
            chk($sformatf("hold_a_done c%0d", c), int'(a_done), int'((c % pa_per) == pa_per - 1));
            chk($sformatf("hold_b_done c%0d", c), int'(b_done), int'((c % pb_per) == pb_per - 1));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("hold_a_idle", int'(a_busy), 0);
        chk("hold_b_idle", int'(b_busy), 0);
        chk("hold_a_data", int'(a_data), 8'hC6);
        chk("hold_b_data", int'(b_data), 8'h29);
        prev_a = 8'hC6;
        prev_b = 8'h29;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            ab = ($urandom_range(0, 99) < 40) ? int'($urandom_range(0, NCYC - 1)) : -1;
            rs = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, NCYC - 2)) : -1;
            run_scan(8'($urandom), 8'($urandom), ab, rs, -1, -1, dca, dcb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
